// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats,
// decode control bundle and the decode-stage stall states.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_e;

   typedef enum logic {
      ST_RUN,
      ST_BUBBLE
   } stall_state_e;

   typedef struct packed {
      imm_type_e imm_type;
      logic      reg_write;
      logic      is_load;
      logic      is_store;
      logic      is_branch;
      logic      uses_rs2;
   } ctrl_t;

   // reg_write here ignores rd; the stage masks writes to x0.
   function automatic ctrl_t decode_ctrl(input logic [6:0] op);
      ctrl_t c;
      c.imm_type  = IMM_NONE;
      c.reg_write = 1'b0;
      c.is_load   = 1'b0;
      c.is_store  = 1'b0;
      c.is_branch = 1'b0;
      c.uses_rs2  = 1'b0;
      unique case (1'b1)
         op == OP_R: begin
            c.reg_write = 1'b1;
            c.uses_rs2  = 1'b1;
         end
         op == OP_I, op == OP_JALR: begin
            c.imm_type  = IMM_I;
            c.reg_write = 1'b1;
         end
         op == OP_LOAD: begin
            c.imm_type  = IMM_I;
            c.reg_write = 1'b1;
            c.is_load   = 1'b1;
         end
         op == OP_STORE: begin
            c.imm_type = IMM_S;
            c.is_store = 1'b1;
            c.uses_rs2 = 1'b1;
         end
         op == OP_BRANCH: begin
            c.imm_type  = IMM_B;
            c.is_branch = 1'b1;
            c.uses_rs2  = 1'b1;
         end
         op == OP_LUI, op == OP_AUIPC: begin
            c.imm_type  = IMM_U;
            c.reg_write = 1'b1;
         end
         op == OP_JAL: begin
            c.imm_type  = IMM_J;
            c.reg_write = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the sign-extended
// immediate for each RV32I instruction format.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm
);

   logic signed [31:0] imm32;
   logic               unused_op;

   assign unused_op = ^instr[6:0];

   always_comb begin
      imm32 = '0;
      unique case (imm_type)
         IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm32 = {{20{instr[31]}}, instr[31:25],
                         instr[11:7]};
         IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
         IMM_U: imm32 = {instr[31:12], 12'b0};
         IMM_J: imm32 = {{11{instr[31]}}, instr[31],
                         instr[19:12], instr[20],
                         instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: operand read with WB bypass, control
// decode, load-use bubble insertion and the ID/EX register.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [XLEN-1:0]       id_instr,
   input  logic [XLEN-1:0]       id_pc,
   output logic [REG_ADDR_W-1:0] rf_a1,
   output logic [REG_ADDR_W-1:0] rf_a2,
   input  logic [XLEN-1:0]       rf_rd1,
   input  logic [XLEN-1:0]       rf_rd2,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_rs1_data,
   output logic [XLEN-1:0]       ex_rs2_data,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [6:0]            ex_opcode,
   output logic [2:0]            ex_funct3,
   output logic                  ex_funct7b5,
   output logic                  ex_reg_write,
   output logic                  ex_is_load,
   output logic                  ex_is_store,
   output logic                  ex_is_branch
);

   logic [6:0]            opcode;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [REG_ADDR_W-1:0] rd;
   ctrl_t                 ctrl;
   logic [XLEN-1:0]       imm;
   logic [XLEN-1:0]       src1;
   logic [XLEN-1:0]       src2;
   logic                  reg_write;
   logic                  hazard;
   logic                  advance;
   logic                  load_en;
   logic                  kill;
   stall_state_e          state_q;
   stall_state_e          state_d;

   assign opcode = id_instr[6:0];
   assign rs1    = REG_ADDR_W'(id_instr[19:15]);
   assign rs2    = REG_ADDR_W'(id_instr[24:20]);
   assign rd     = REG_ADDR_W'(id_instr[11:7]);
   assign rf_a1  = rs1;
   assign rf_a2  = rs2;

   assign ctrl      = decode_ctrl(opcode);
   assign reg_write = ctrl.reg_write & (rd != '0);

   imm_gen #(
      .XLEN(XLEN)
   ) u_imm_gen (
      .instr    (id_instr[31:0]),
      .imm_type (ctrl.imm_type),
      .imm      (imm)
   );

   // x0 wins over the bypass, so a WB write to x0 never leaks.
   always_comb begin
      src1 = rf_rd1;
      if (rs1 == '0)
         src1 = '0;
      else if (wb_we && wb_rd == rs1)
         src1 = wb_data;
   end

   always_comb begin
      src2 = rf_rd2;
      if (rs2 == '0)
         src2 = '0;
      else if (wb_we && wb_rd == rs2)
         src2 = wb_data;
   end

   assign hazard = ex_valid & ex_is_load & (ex_rd != '0) &
                   ((ex_rd == rs1) |
                    (ctrl.uses_rs2 & (ex_rd == rs2)));

   assign advance  = ex_ready | ~ex_valid;
   assign id_ready = flush | (advance & ~hazard);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_RUN;
      else
         state_q <= state_d;
   end

   // flush clears ID/EX even while execute is holding it.
   always_comb begin
      state_d = state_q;
      load_en = 1'b0;
      kill    = 1'b0;
      if (flush)
         kill = 1'b1;
      else if (advance) begin
         if (hazard)
            kill = 1'b1;
         else
            load_en = 1'b1;
      end
      unique case (state_q)
         ST_RUN:
            if (!flush && hazard && advance)
               state_d = ST_BUBBLE;
         ST_BUBBLE:
            state_d = ST_RUN;
         default:
            state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rd        <= '0;
         ex_opcode    <= '0;
         ex_funct3    <= '0;
         ex_funct7b5  <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_is_store  <= 1'b0;
         ex_is_branch <= 1'b0;
      end else if (kill) begin
         ex_valid <= 1'b0;
      end else if (load_en) begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         ex_rs1_data  <= src1;
         ex_rs2_data  <= src2;
         ex_imm       <= imm;
         ex_rd        <= rd;
         ex_opcode    <= opcode;
         ex_funct3    <= id_instr[14:12];
         ex_funct7b5  <= id_instr[30];
         ex_reg_write <= reg_write;
         ex_is_load   <= ctrl.is_load;
         ex_is_store  <= ctrl.is_store;
         ex_is_branch <= ctrl.is_branch;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents
// are queued at issue and compared when ex_valid appears.
module tb_decode_stage;
   import riscv_pkg::*;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7b5;
      logic        rw;
      logic        ld;
      logic        st;
      logic        br;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [31:0] id_instr = '0;
   logic [31:0] id_pc = '0;
   logic [4:0]  rf_a1, rf_a2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b1;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5, ex_reg_write;
   logic        ex_is_load, ex_is_store, ex_is_branch;

   logic [31:0] rf [32];
   exp_t        sb [$];
   exp_t        e;
   exp_t        beq_e;
   int          n_cmp = 0;
   int          n_err = 0;

   localparam logic [31:0] ADD  = 32'h006283B3;
   localparam logic [31:0] LW   = 32'h00432283;
   localparam logic [31:0] BEQ  = 32'hFE000EE3;
   localparam logic [31:0] ADDI = 32'hFFF00093;
   localparam logic [31:0] LUI  = 32'h12345137;
   localparam logic [31:0] SW   = 32'h0062A423;
   localparam logic [31:0] UNK  = 32'h0000007F;

   assign rf_rd1 = rf[rf_a1];
   assign rf_rd2 = rf[rf_a2];

   always #5 clk = ~clk;

   decode_stage dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .rf_a1        (rf_a1),
      .rf_a2        (rf_a2),
      .rf_rd1       (rf_rd1),
      .rf_rd2       (rf_rd2),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_pc        (ex_pc),
      .ex_rs1_data  (ex_rs1_data),
      .ex_rs2_data  (ex_rs2_data),
      .ex_imm       (ex_imm),
      .ex_rd        (ex_rd),
      .ex_opcode    (ex_opcode),
      .ex_funct3    (ex_funct3),
      .ex_funct7b5  (ex_funct7b5),
      .ex_reg_write (ex_reg_write),
      .ex_is_load   (ex_is_load),
      .ex_is_store  (ex_is_store),
      .ex_is_branch (ex_is_branch)
   );

   function automatic exp_t mk(
      input logic [31:0] pc, ins, a, b, imm,
      input logic rw, ld, st, br);
      exp_t x;
      x.valid = 1'b1;
      x.pc    = pc;
      x.rs1   = a;
      x.rs2   = b;
      x.imm   = imm;
      x.rd    = ins[11:7];
      x.op    = ins[6:0];
      x.f3    = ins[14:12];
      x.f7b5  = ins[30];
      x.rw    = rw;
      x.ld    = ld;
      x.st    = st;
      x.br    = br;
      return x;
   endfunction

   function automatic exp_t obs();
      exp_t x;
      x.valid = ex_valid;
      x.pc    = ex_pc;
      x.rs1   = ex_rs1_data;
      x.rs2   = ex_rs2_data;
      x.imm   = ex_imm;
      x.rd    = ex_rd;
      x.op    = ex_opcode;
      x.f3    = ex_funct3;
      x.f7b5  = ex_funct7b5;
      x.rw    = ex_reg_write;
      x.ld    = ex_is_load;
      x.st    = ex_is_store;
      x.br    = ex_is_branch;
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins,
                        input logic [31:0] pc);
      id_valid = 1'b1;
      id_instr = ins;
      id_pc    = pc;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_cmp++;
      if (obs() !== exp_t'(0)) begin
         n_err++;
         $display("FAIL reset_ex: got %h want 0", obs());
      end
      n_cmp++;
      if (id_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 1", id_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      drive(ADD, 32'h100);
      sb.push_back(mk(32'h100, ADD, 5, 1, 0, 1, 0, 0, 0));
      tick();
      id_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
         n_err++;
         $display("FAIL add: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_load_use();
      drive(LW, 32'h104);
      sb.push_back(mk(32'h104, LW, 1, 0, 4, 1, 1, 0, 0));
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
         n_err++;
         $display("FAIL lw: got %h want %h", obs(), e);
      end
      drive(ADD, 32'h108);
      #1;
      n_cmp++;
      if (id_ready !== 1'b0) begin
         n_err++;
         $display("FAIL hz_ready: got %b want 0", id_ready);
      end
      tick();
      n_cmp++;
      if (ex_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bubble: got %b want 0", ex_valid);
      end
      n_cmp++;
      if (dut.state_q !== ST_BUBBLE) begin
         n_err++;
         $display("FAIL st_bub: got %0d want %0d",
                  dut.state_q, ST_BUBBLE);
      end
      wb_we   = 1'b1;
      wb_rd   = 5'd5;
      wb_data = 32'h1234;
      #1;
      n_cmp++;
      if (id_ready !== 1'b1) begin
         n_err++;
         $display("FAIL retry_ready: got %b want 1", id_ready);
      end
      sb.push_back(mk(32'h108, ADD, 32'h1234, 1, 0, 1, 0, 0, 0));
      tick();
      wb_we = 1'b0;
      id_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
         n_err++;
         $display("FAIL add_byp: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [4];
      exp_t        ex [4];
      ins[0] = ADDI;
      ins[1] = LUI;
      ins[2] = SW;
      ins[3] = UNK;
      ex[0] = mk(32'h200, ADDI, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
      ex[1] = mk(32'h204, LUI, 0, 0, 32'h12345000, 1, 0, 0, 0);
      ex[2] = mk(32'h208, SW, 5, 1, 8, 0, 0, 1, 0);
      ex[3] = mk(32'h20C, UNK, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(ins[i], 32'h200 + 32'(4 * i));
         sb.push_back(ex[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if (obs() !== e) begin
            n_err++;
            $display("FAIL b2b%0d: got %h want %h", i, obs(), e);
         end
      end
      id_valid = 1'b0;
   endtask

   task automatic test_branch_x0();
      beq_e = mk(32'h300, BEQ, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 1);
      drive(BEQ, 32'h300);
      wb_we   = 1'b1;
      wb_rd   = 5'd0;
      wb_data = 32'hDEAD;
      sb.push_back(beq_e);
      tick();
      wb_we = 1'b0;
      id_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
         n_err++;
         $display("FAIL beq: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_hold_flush();
      ex_ready = 1'b0;
      drive(ADD, 32'h304);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (id_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_rdy%0d: got %b want 0", i, id_ready);
         end
         tick();
         n_cmp++;
         if (obs() !== beq_e) begin
            n_err++;
            $display("FAIL hold%0d: got %h want %h",
                     i, obs(), beq_e);
         end
      end
      flush = 1'b1;
      #1;
      n_cmp++;
      if (id_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_rdy: got %b want 1", id_ready);
      end
      tick();
      n_cmp++;
      if (ex_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush: got %b want 0", ex_valid);
      end
      flush    = 1'b0;
      id_valid = 1'b0;
      ex_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_bubble();
      drive(LW, 32'h400);
      tick();
      drive(ADD, 32'h404);
      tick();
      n_cmp++;
      if (dut.state_q !== ST_BUBBLE) begin
         n_err++;
         $display("FAIL rb_state: got %0d want %0d",
                  dut.state_q, ST_BUBBLE);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== exp_t'(0)) begin
         n_err++;
         $display("FAIL rb_clear: got %h want 0", obs());
      end
      n_cmp++;
      if (dut.state_q !== ST_RUN) begin
         n_err++;
         $display("FAIL rb_run: got %0d want %0d",
                  dut.state_q, ST_RUN);
      end
      tick();
      rst = 1'b0;
      sb.push_back(mk(32'h404, ADD, 5, 1, 0, 1, 0, 0, 0));
      tick();
      id_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (obs() !== e) begin
         n_err++;
         $display("FAIL rb_add: got %h want %h", obs(), e);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[5] = 32'd5;
      rf[6] = 32'd1;
      test_reset();
      test_add();
      test_load_use();
      test_back_to_back();
      test_branch_x0();
      test_hold_flush();
      test_reset_bubble();
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_left: got %0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
